// File: rtl/sram_1r1w_mask_init_if.sv
// Bus bundle for the 1R1W masked SRAM: one read port (R0), one masked
// write port (W0) and the init_done status flag.
interface sram_1r1w_mask_init_if #(
  parameter int ADDR_W   = 8,
  parameter int WIDTH    = 48,
  parameter int MASK_SEG = 8
);
  logic                R0_en;
  logic [ADDR_W-1:0]   R0_addr;
  logic [WIDTH-1:0]    R0_data;
  logic                W0_en;
  logic [ADDR_W-1:0]   W0_addr;
  logic [MASK_SEG-1:0] W0_mask;
  logic [WIDTH-1:0]    W0_data;
  logic                init_done;

  // Requester side: issues reads/writes, observes read data and init status.
  modport master (
    output R0_en, R0_addr, W0_en, W0_addr, W0_mask, W0_data,
    input  R0_data, init_done
  );

  // Memory side: accepts requests, returns read data and init status.
  modport slave (
    input  R0_en, R0_addr, W0_en, W0_addr, W0_mask, W0_data,
    output R0_data, init_done
  );
endinterface

// File: rtl/sram_1r1w_mask_init.sv
// 1-read / 1-write SRAM with per-segment write mask and a power-up clear
// sweep. After reset the array is zeroed one entry per cycle (DEPTH cycles);
// init_done rises when the sweep finishes and only then are requests honoured.
// Read latency is one cycle and R0_data holds its last value while idle.
//
// Compile macro SRAM_WR_BYPASS_EN: when defined, a same-address read/write
// returns the newly written segments merged with the old unmasked segments;
// when undefined (default) the read returns the old entry (read-first).
module sram_1r1w_mask_init #(
  parameter int DEPTH    = 256,
  parameter int WIDTH    = 48,
  parameter int MASK_SEG = 8
) (
  input logic                   clock,
  input logic                   reset,
  sram_1r1w_mask_init_if.slave  bus
);

  localparam int MASK_GRAN = WIDTH / MASK_SEG;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Replicate each mask bit across the data bits of its segment.
  function automatic logic [WIDTH-1:0] expand_mask(input logic [MASK_SEG-1:0] m);
    logic [WIDTH-1:0] bits;
    bits = {WIDTH{1'b0}};
    for (int i = 0; i < MASK_SEG; i++) begin
      bits[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{m[i]}};
    end
    return bits;
  endfunction

  state_t            state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              init_done_r;
  logic [WIDTH-1:0]  r0_data_r;
  logic [WIDTH-1:0]  mem_r [DEPTH];

  logic [WIDTH-1:0]  w0_bits_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [WIDTH-1:0]  wr_bits_s;
  logic [WIDTH-1:0]  wr_data_s;
  logic [WIDTH-1:0]  rd_value_s;

  assign w0_bits_s     = expand_mask(bus.W0_mask);
  assign bus.R0_data   = r0_data_r;
  assign bus.init_done = init_done_r;

  // Clear-sweep FSM: walk the counter over every entry, then park in READY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= CLEAR;
      cnt_r       <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          if (cnt_r == LAST_ADDR) begin
            state_r     <= READY;
            init_done_r <= 1'b1;
          end else begin
            cnt_r       <= cnt_r + ADDR_W'(1);
          end
        end
        READY: begin
          state_r     <= READY;
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= CLEAR;
          cnt_r       <= {ADDR_W{1'b0}};
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Write-port mux: the sweep owns the array in CLEAR, the user port in READY.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = {ADDR_W{1'b0}};
    wr_bits_s = {WIDTH{1'b0}};
    wr_data_s = {WIDTH{1'b0}};
    case (state_r)
      CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = cnt_r;
        wr_bits_s = {WIDTH{1'b1}};
        wr_data_s = {WIDTH{1'b0}};
      end
      READY: begin
        wr_en_s   = bus.W0_en;
        wr_addr_s = bus.W0_addr;
        wr_bits_s = w0_bits_s;
        wr_data_s = bus.W0_data;
      end
      default: begin
        wr_en_s   = 1'b0;
      end
    endcase
  end

  // Array write with per-bit merge; contents are never reset, only swept.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= (mem_r[wr_addr_s] & ~wr_bits_s) | (wr_data_s & wr_bits_s);
    end
  end

  // Read value selection, including same-address collision handling.
  always_comb begin
    rd_value_s = mem_r[bus.R0_addr];
`ifdef SRAM_WR_BYPASS_EN
    if (bus.W0_en && (bus.W0_addr == bus.R0_addr)) begin
      rd_value_s = (mem_r[bus.R0_addr] & ~w0_bits_s) | (bus.W0_data & w0_bits_s);
    end else begin
      rd_value_s = mem_r[bus.R0_addr];
    end
`else
    if (bus.W0_en && (bus.W0_addr == bus.R0_addr)) begin
      rd_value_s = mem_r[bus.R0_addr];
    end else begin
      rd_value_s = mem_r[bus.R0_addr];
    end
`endif
  end

  // Read data register: capture only on an accepted read, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r0_data_r <= {WIDTH{1'b0}};
    end else if (init_done_r && bus.R0_en) begin
      r0_data_r <= rd_value_s;
    end else begin
      r0_data_r <= r0_data_r;
    end
  end

endmodule

// File: tb/tb_sram_1r1w_mask_init.sv
// Directed bench for sram_1r1w_mask_init (DEPTH=256, WIDTH=48, MASK_SEG=8).
module tb_sram_1r1w_mask_init;

  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;

  sram_1r1w_mask_init_if #(.ADDR_W(8), .WIDTH(48), .MASK_SEG(8)) bus ();

  sram_1r1w_mask_init #(.DEPTH(256), .WIDTH(48), .MASK_SEG(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    bus.R0_en   = 1'b0;
    bus.R0_addr = 8'd0;
    bus.W0_en   = 1'b0;
    bus.W0_addr = 8'd0;
    bus.W0_mask = 8'h00;
    bus.W0_data = 48'h0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] m, input logic [47:0] d);
    bus.W0_en = 1'b1; bus.W0_addr = a; bus.W0_mask = m; bus.W0_data = d;
    @(posedge clock); #1;
    bus.W0_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [47:0] d);
    bus.R0_en = 1'b1; bus.R0_addr = a;
    @(posedge clock); #1;
    bus.R0_en = 1'b0;
    d = bus.R0_data;
  endtask

  // Release reset and count cycles until init_done; returns count (or budget).
  task automatic release_and_count(output int cycles);
    reset  = 1'b0;
    cycles = 0;
    while (cycles < 1000 && bus.init_done !== 1'b1) begin
      @(posedge clock); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_total++;
    if (bus.R0_data !== 48'h0 || bus.init_done !== 1'b0)
      $display("FAIL reset_state: R0_data=%h init_done=%b, want 0/0", bus.R0_data, bus.init_done);
    else n_pass++;
  endtask

  // Requests issued during the sweep must be dropped.
  task automatic test_clear_requests();
    int cycles;
    reset  = 1'b0;
    cycles = 0;
    while (cycles < 1000 && bus.init_done !== 1'b1) begin
      if (cycles == 10) begin
        bus.W0_en = 1'b1; bus.W0_addr = 8'd9; bus.W0_mask = 8'hFF; bus.W0_data = 48'hFFFF_FFFF_FFFF;
        bus.R0_en = 1'b1; bus.R0_addr = 8'd9;
      end else begin
        idle_inputs();
      end
      @(posedge clock); #1;
      cycles++;
      if (cycles == 11) begin
        n_total++;
        if (bus.R0_data !== 48'h0 || bus.init_done !== 1'b0)
          $display("FAIL clear_read_ignored: R0_data=%h init_done=%b, want 0/0", bus.R0_data, bus.init_done);
        else n_pass++;
      end
    end
    idle_inputs();
    n_total++;
    if (cycles !== 256)
      $display("FAIL init_latency: %0d cycles, want 256", cycles);
    else n_pass++;
  endtask

  task automatic test_clear_reads();
    logic [47:0] d;
    logic [7:0]  addrs [4];
    addrs[0] = 8'd0; addrs[1] = 8'd128; addrs[2] = 8'd255; addrs[3] = 8'd9;
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i], d);
      n_total++;
      if (d !== 48'h0)
        $display("FAIL cleared_read[%0d]: got %h, want 0", addrs[i], d);
      else n_pass++;
    end
  endtask

  task automatic test_masked_write();
    logic [47:0] d;
    do_write(8'd5, 8'hFF, 48'hFFFF_FFFF_FFFF);
    do_write(8'd5, 8'h0F, 48'h0);
    do_write(8'd5, 8'h00, 48'h1234_5678_9ABC);
    do_read(8'd5, d);
    n_total++;
    if (d !== 48'hFFFF_FF00_0000)
      $display("FAIL masked_write: got %h, want ffffff000000", d);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [47:0] d;
    logic [47:0] exp_col;
`ifdef SRAM_WR_BYPASS_EN
    exp_col = 48'h1111_1111_112A;
`else
    exp_col = 48'h1111_1111_1111;
`endif
    do_write(8'd7, 8'hFF, 48'h1111_1111_1111);
    bus.R0_en = 1'b1; bus.R0_addr = 8'd7;
    bus.W0_en = 1'b1; bus.W0_addr = 8'd7; bus.W0_mask = 8'h01; bus.W0_data = 48'hAAAA_AAAA_AAAA;
    @(posedge clock); #1;
    idle_inputs();
    n_total++;
    if (bus.R0_data !== exp_col)
      $display("FAIL collision_read: got %h, want %h", bus.R0_data, exp_col);
    else n_pass++;
    do_read(8'd7, d);
    n_total++;
    if (d !== 48'h1111_1111_112A)
      $display("FAIL collision_after: got %h, want 11111111112a", d);
    else n_pass++;
  endtask

  task automatic test_read_hold();
    logic [47:0] d;
    int          bad;
    do_write(8'd3, 8'hFF, 48'h5A);
    do_read(8'd3, d);
    n_total++;
    if (d !== 48'h5A) $display("FAIL hold_initial: got %h, want 5a", d);
    else n_pass++;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      bus.W0_en = 1'b1; bus.W0_addr = 8'd3; bus.W0_mask = 8'hFF; bus.W0_data = 48'(i);
      bus.R0_en = 1'b0; bus.R0_addr = 8'd3;
      @(posedge clock); #1;
      if (bus.R0_data !== 48'h5A) bad++;
    end
    idle_inputs();
    n_total++;
    if (bad != 0) $display("FAIL read_hold: %0d cycles changed, want 0 (R0_data=%h)", bad, bus.R0_data);
    else n_pass++;
    do_read(8'd3, d);
    n_total++;
    if (d !== 48'd10) $display("FAIL hold_writes_landed: got %h, want a", d);
    else n_pass++;
  endtask

  // Simultaneous read and write to different addresses.
  task automatic test_back_to_back();
    logic [47:0] d;
    bus.R0_en = 1'b1; bus.R0_addr = 8'd5;
    bus.W0_en = 1'b1; bus.W0_addr = 8'd20; bus.W0_mask = 8'hF0; bus.W0_data = 48'hCAFE_BABE_1234;
    @(posedge clock); #1;
    idle_inputs();
    n_total++;
    if (bus.R0_data !== 48'hFFFF_FF00_0000)
      $display("FAIL diff_addr_read: got %h, want ffffff000000", bus.R0_data);
    else n_pass++;
    do_read(8'd20, d);
    n_total++;
    if (d !== 48'hCAFE_BA00_0000)
      $display("FAIL diff_addr_write: got %h, want cafeba000000", d);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [47:0] d;
    int          cycles;
    // R0_data is nonzero here (last read of addr 20); reset must clear it at once.
    reset = 1'b1;
    #1;
    n_total++;
    if (bus.R0_data !== 48'h0 || bus.init_done !== 1'b0)
      $display("FAIL reset_mid_op: R0_data=%h init_done=%b, want 0/0", bus.R0_data, bus.init_done);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (100) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    n_total++;
    if (bus.R0_data !== 48'h0 || bus.init_done !== 1'b0)
      $display("FAIL reset_mid_sweep: R0_data=%h init_done=%b, want 0/0", bus.R0_data, bus.init_done);
    else n_pass++;
    @(posedge clock); #1;
    release_and_count(cycles);
    n_total++;
    if (cycles !== 256) $display("FAIL resweep_latency: %0d cycles, want 256", cycles);
    else n_pass++;
    do_read(8'd5, d);
    n_total++;
    if (d !== 48'h0) $display("FAIL resweep_addr5: got %h, want 0", d);
    else n_pass++;
    do_read(8'd20, d);
    n_total++;
    if (d !== 48'h0) $display("FAIL resweep_addr20: got %h, want 0", d);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    idle_inputs();
    test_reset();
    test_clear_requests();
    test_clear_reads();
    test_masked_write();
    test_collision();
    test_read_hold();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
